// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_pkg;

  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_DROP  = 2'd2,
    S_HOLD  = 2'd3
  } fetch_state_e;

  // Instructions are word aligned; the low two address bits are always dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// Single-slot {valid, pc, instr} holding register for a fetched word decode cannot take yet.
// Latency: load visible the cycle after the load edge; unload/flush empty it on the next edge.
// Backpressure: none internally; the owner never loads while it is full.
module fetch_skid_buffer
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        unload,
  input  logic        flush,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_instr,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] instr
);

  // Flush beats load so a redirect can never leave a wrong-path word parked here.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid <= 1'b0;
      pc    <= 32'h0000_0000;
      instr <= NOP_INSTR;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      instr <= load_instr;
    end else if (unload) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the fetch PC, runs the imem handshake, presents {pc, instr, valid} to decode.
// Latency: zero-wait memory gives first valid 2 cycles after reset release, then 1 instr/cycle.
// Backpressure: stall_i holds the output; one in-flight word lands in the skid and fetch pauses until drained.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_instr_o
);

  fetch_state_e state;
  fetch_state_e state_next;
  logic [31:0]  fetch_pc;
  logic [31:0]  fetch_pc_next;
  logic [31:0]  redirect_tgt;
  logic [31:0]  pc_inc;
  logic         out_free;

  // Datapath controls decoded by the FSM.
  logic         out_load_mem;
  logic         out_load_skid;
  logic         skid_load;
  logic         skid_unload;
  logic         flush;

  logic         skid_valid;
  logic [31:0]  skid_pc;
  logic [31:0]  skid_instr;

  assign redirect_tgt = align_pc(redirect_pc_i);
  // 32-bit add wraps 32'hFFFF_FFFC to 0 naturally.
  assign pc_inc       = fetch_pc + 32'(INSTR_BYTES);
  // Output register may take a new word if it is empty or decode is consuming it now.
  assign out_free     = !if_valid_o || !stall_i;
  assign imem_addr_o  = fetch_pc;

  fetch_skid_buffer u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (skid_load),
    .unload     (skid_unload),
    .flush      (flush),
    .load_pc    (fetch_pc),
    .load_instr (imem_rdata_i),
    .valid      (skid_valid),
    .pc         (skid_pc),
    .instr      (skid_instr)
  );

  // State and fetch PC registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_RESET;
      fetch_pc <= RESET_VECTOR;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
    end
  end

  // Next-state, next-PC and datapath control; redirect outranks response, which outranks stall.
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    imem_req_o    = 1'b0;
    out_load_mem  = 1'b0;
    out_load_skid = 1'b0;
    skid_load     = 1'b0;
    skid_unload   = 1'b0;
    flush         = 1'b0;

    case (state)
      S_RESET: begin
        // Any response seen here belongs to a pre-reset request and is ignored.
        state_next = S_FETCH;
        if (redirect_i) begin
          flush         = 1'b1;
          fetch_pc_next = redirect_tgt;
        end
      end

      S_FETCH: begin
        imem_req_o = 1'b1;
        if (redirect_i) begin
          flush         = 1'b1;
          fetch_pc_next = redirect_tgt;
          // An unanswered request must still be drained before refetching.
          state_next    = imem_ready_i ? S_FETCH : S_DROP;
        end else if (imem_ready_i) begin
          fetch_pc_next = pc_inc;
          if (out_free) begin
            out_load_mem = 1'b1;
          end else begin
            skid_load  = 1'b1;
            state_next = S_HOLD;
          end
        end
      end

      S_DROP: begin
        if (redirect_i) begin
          flush         = 1'b1;
          fetch_pc_next = redirect_tgt;
        end
        // If the stale word lands alongside a newer redirect it is still the
        // only outstanding response, so leaving here avoids waiting forever.
        if (imem_ready_i) begin
          state_next = S_FETCH;
        end
      end

      S_HOLD: begin
        if (redirect_i) begin
          flush         = 1'b1;
          fetch_pc_next = redirect_tgt;
          state_next    = S_FETCH;
        end else if (!stall_i) begin
          out_load_skid = skid_valid;
          skid_unload   = 1'b1;
          state_next    = S_FETCH;
        end
      end

      default: begin
        state_next = S_RESET;
      end
    endcase
  end

  // Output register to decode: held while stalled and valid, drained when decode takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid_o <= 1'b0;
      if_pc_o    <= 32'h0000_0000;
      if_instr_o <= NOP_INSTR;
    end else if (flush) begin
      if_valid_o <= 1'b0;
      if_instr_o <= NOP_INSTR;
    end else if (out_load_mem) begin
      if_valid_o <= 1'b1;
      if_pc_o    <= fetch_pc;
      if_instr_o <= imem_rdata_i;
    end else if (out_load_skid) begin
      if_valid_o <= 1'b1;
      if_pc_o    <= skid_pc;
      if_instr_o <= skid_instr;
    end else if (!stall_i) begin
      if_valid_o <= 1'b0;
      if_instr_o <= NOP_INSTR;
    end
  end

endmodule
